// File: rtl/c3lib_rstseq_ctrl.sv
// c3lib_rstseq_ctrl: releases NUM_RST reset domains one at a time after a synchronized reset release.
// Define C3LIB_RSTSEQ_ACK_TIMEOUT_EN to bound each acknowledge wait to TIMEOUT cycles (sticky ack_timeout).
module c3lib_rstseq_ctrl #(
    parameter int unsigned        NUM_RST     = 4,
    parameter int unsigned        DLY_W       = 8,
    parameter int unsigned        RELEASE_DLY = 16,
    parameter logic [NUM_RST-1:0] ACK_MASK    = '0,
    parameter int unsigned        TIMEOUT     = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_mode_n,
    input  logic               rst_n_bypass,
    input  logic               sw_rst_req,
    input  logic [NUM_RST-1:0] rst_ack,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               seq_done,
    output logic               ack_timeout
);

    localparam int unsigned        IDX_W    = $clog2(NUM_RST);
    localparam logic [IDX_W-1:0]   LAST     = IDX_W'(NUM_RST - 1);
    localparam logic [DLY_W-1:0]   DLY_LOAD = DLY_W'(RELEASE_DLY - 1);

    if (NUM_RST < 2 || NUM_RST > 16 || RELEASE_DLY < 1 ||
        RELEASE_DLY > (2 ** DLY_W) - 1 || TIMEOUT < 1) begin : g_bad_param
        $error("c3lib_rstseq_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {HOLD, DLY, ACK, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [DLY_W-1:0]   cnt;
    logic [NUM_RST-1:0] out_q;
    logic               done_q;
    logic [1:0]         sync_q;
    logic               rst_sync;
    logic               rst_n_int;
    logic               ack_go;

    // In scan mode the bypass pin owns the reset tree, including this block's own flops.
    assign rst_n_int = scan_mode_n ? rst_n : rst_n_bypass;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) sync_q <= '0;
        else            sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_sync = sync_q[1];

`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;
    logic            tmo_hit;
    logic            to_q;
    // A timed-out wait advances exactly like an ack; a real ack on the last cycle wins the flag.
    assign tmo_hit     = (tcnt == TO_W'(TIMEOUT - 1));
    assign ack_go      = rst_ack[idx] | tmo_hit;
    assign ack_timeout = to_q;
`else
    assign ack_go      = rst_ack[idx];
    assign ack_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state  <= HOLD;
            idx    <= '0;
            cnt    <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
            tcnt   <= '0;
            to_q   <= 1'b0;
`endif
        end else if (sw_rst_req) begin
            state  <= HOLD;
            idx    <= '0;
            cnt    <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
            tcnt   <= '0;
            to_q   <= 1'b0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (rst_sync) begin
                        state <= DLY;
                        cnt   <= DLY_LOAD;
                        idx   <= '0;
                    end
                end
                DLY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_q[idx] <= 1'b1;
                        if (ACK_MASK[idx]) begin
                            state <= ACK;
`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                            cnt <= DLY_LOAD;
                        end
                    end
                end
                ACK: begin
`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
                    if (tmo_hit && !rst_ack[idx]) to_q <= 1'b1;
`endif
                    if (ack_go) begin
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            state <= DLY;
                            idx   <= idx + 1'b1;
                            cnt   <= DLY_LOAD;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    out_q  <= '1;
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign rst_n_out = scan_mode_n ? out_q  : {NUM_RST{rst_n_bypass}};
    assign seq_done  = scan_mode_n ? done_q : rst_n_bypass;

endmodule

// File: tb/tb_c3lib_rstseq_ctrl.sv
// Bench for c3lib_rstseq_ctrl: two instances (no-ack default, ACK_MASK=4'b0101) against a release-timeline model.
// Honors C3LIB_RSTSEQ_ACK_TIMEOUT_EN when the same macro is defined for the build.
module tb_c3lib_rstseq_ctrl;

    localparam int        N      = 4;
    localparam int        RD     = 16;
    localparam int        TO     = 1023;
    localparam logic [3:0] MASK_B = 4'b0101;
`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, scan_mode_n, rst_n_bypass, sw_rst_req;
    logic [3:0] ack_a, ack_b;
    logic [3:0] out_a, out_b;
    logic       done_a, done_b, to_a, to_b;

    always #5 clk = ~clk;

    c3lib_rstseq_ctrl #(.NUM_RST(N)) dut_a (
        .clk(clk), .rst_n(rst_n), .scan_mode_n(scan_mode_n), .rst_n_bypass(rst_n_bypass),
        .sw_rst_req(sw_rst_req), .rst_ack(ack_a), .rst_n_out(out_a), .seq_done(done_a),
        .ack_timeout(to_a));

    c3lib_rstseq_ctrl #(.NUM_RST(N), .ACK_MASK(MASK_B), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .scan_mode_n(scan_mode_n), .rst_n_bypass(rst_n_bypass),
        .sw_rst_req(sw_rst_req), .rst_ack(ack_b), .rst_n_out(out_b), .seq_done(done_b),
        .ack_timeout(to_b));

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    // Timeline model: released-stage count, edges left until the next release, ack wait bookkeeping.
    bit m_s1[2], m_s2[2], m_armed[2], m_wt[2], m_fin[2], m_done[2], m_to[2];
    int m_rel[2], m_left[2], m_wcnt[2];

    function automatic logic [3:0] mask_of(input int k);
        return (k == 0) ? 4'b0000 : MASK_B;
    endfunction

    function automatic void advance(input int k);
        m_wt[k] = 1'b0;
        if (m_rel[k] == N) m_fin[k] = 1'b1;
        else               m_left[k] = RD;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            logic       rint;
            logic [3:0] ack;
            bit         was_s2;
            rint = scan_mode_n ? rst_n : rst_n_bypass;
            ack  = (k == 0) ? ack_a : ack_b;
            if (!rint) begin
                m_s1[k] = 0; m_s2[k] = 0; m_armed[k] = 0; m_wt[k] = 0; m_fin[k] = 0;
                m_done[k] = 0; m_to[k] = 0; m_rel[k] = 0;
            end else begin
                was_s2  = m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = 1'b1;
                if (sw_rst_req) begin
                    m_armed[k] = 0; m_wt[k] = 0; m_fin[k] = 0; m_done[k] = 0; m_to[k] = 0; m_rel[k] = 0;
                end else if (!m_armed[k]) begin
                    if (was_s2) begin m_armed[k] = 1; m_left[k] = RD; end
                end else if (m_fin[k]) begin
                    m_done[k] = 1'b1;
                end else if (m_wt[k]) begin
                    m_wcnt[k]++;
                    if (ack[m_rel[k]-1]) advance(k);
                    else if (TO_EN && m_wcnt[k] == TO) begin m_to[k] = 1'b1; advance(k); end
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_rel[k]++;
                        if (mask_of(k)[m_rel[k]-1]) begin m_wt[k] = 1'b1; m_wcnt[k] = 0; end
                        else advance(k);
                    end
                end
            end
        end
    end

    function automatic logic [5:0] exp_of(input int k);
        logic [3:0] o;
        logic d, t, rint;
        rint = scan_mode_n ? rst_n : rst_n_bypass;
        o = 4'((1 << m_rel[k]) - 1);
        d = m_done[k];
        t = m_to[k];
        if (!rint) begin o = 4'b0; d = 1'b0; t = 1'b0; end
        if (!scan_mode_n) begin o = {4{rst_n_bypass}}; d = rst_n_bypass; end
        return {o, d, t};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {exp_of(0), exp_of(1)};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {out_a, done_a, to_a, out_b, done_b, to_b};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_a, done_a, to_a, out_b, done_b, to_b} !== 12'b0) begin
                miscompares++;
                $display("FAIL reset_state obs=%b exp=%b", obs_vec(), 12'b0);
            end
            ack_a = 4'($urandom);
            ack_b = 4'($urandom);
        end
    endtask

    task automatic test_default_seq();
        int base;
        int rise[4];
        int drise;
        rise = '{0, 0, 0, 0};
        drise = 0;
        ack_b = 4'b1111;
        rst_n = 1'b1;
        base = edge_n;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL default_seq edge=%0d obs=%b exp=%b", edge_n - base, obs_vec(), exp_vec());
            end
            for (int i = 0; i < 4; i++) if (rise[i] == 0 && out_a[i]) rise[i] = edge_n - base;
            if (drise == 0 && done_a) drise = edge_n - base;
            ack_a = 4'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rise[i] !== 19 + 16 * i) begin
                miscompares++;
                $display("FAIL release_edge[%0d] got=E%0d want=E%0d", i, rise[i], 19 + 16 * i);
            end
        end
        vectors++;
        if (drise !== 68) begin
            miscompares++;
            $display("FAIL seq_done_edge got=E%0d want=E68", drise);
        end
    endtask

    task automatic test_ack_wait();
        int base, r2, ea, r3;
        apply_reset();
        ack_b = 4'b0001;
        rst_n = 1'b1;
        base = edge_n;
        r2 = 0; ea = 0; r3 = 0;
        for (int c = 0; c < 200 && r3 == 0; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ack_wait edge=%0d obs=%b exp=%b", edge_n - base, obs_vec(), exp_vec());
            end
            if (r2 == 0 && out_b[2]) r2 = edge_n;
            if (r3 == 0 && out_b[3]) r3 = edge_n;
            if (r2 != 0 && ea == 0 && edge_n - r2 == 40) begin
                ack_b[2] = 1'b1;
                ea = edge_n + 1;
            end
            ack_a = 4'($urandom);
        end
        vectors++;
        if (r2 - base !== 52) begin
            miscompares++;
            $display("FAIL ack_stage2_edge got=E%0d want=E52", r2 - base);
        end
        vectors++;
        if (r3 == 0 || r3 - ea !== 16) begin
            miscompares++;
            $display("FAIL ack_to_release got=%0d want=16 (r3=%0d)", r3 - ea, r3);
        end
    endtask

    task automatic test_sw_req();
        int eq, r0, c;
        apply_reset();
        ack_b = 4'b1111;
        rst_n = 1'b1;
        c = 0;
        while (out_a !== 4'b0011 && c < 100) begin
            @(negedge clk);
            c++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sw_req_pre obs=%b exp=%b", obs_vec(), exp_vec());
            end
        end
        sw_rst_req = 1'b1;
        @(negedge clk);
        eq = edge_n;
        vectors++;
        if (out_a !== 4'b0000 || c >= 100) begin
            miscompares++;
            $display("FAIL sw_req_clear obs=%b exp=0000", out_a);
        end
        sw_rst_req = 1'b0;
        r0 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sw_req_post obs=%b exp=%b", obs_vec(), exp_vec());
            end
            if (r0 == 0 && out_a[0]) r0 = edge_n;
        end
        vectors++;
        if (r0 - eq !== 17) begin
            miscompares++;
            $display("FAIL sw_req_restart got=%0d want=17", r0 - eq);
        end
    endtask

    task automatic test_async_reset();
        int base, r0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_a, out_b, done_a, done_b} !== 10'b0) begin
            miscompares++;
            $display("FAIL async_clear obs=%b exp=0", {out_a, out_b, done_a, done_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = edge_n;
        r0 = 0;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL async_restart obs=%b exp=%b", obs_vec(), exp_vec());
            end
            if (r0 == 0 && out_a[0]) r0 = edge_n - base;
        end
        vectors++;
        if (r0 !== 19) begin
            miscompares++;
            $display("FAIL async_restart_edge got=E%0d want=E19", r0);
        end
    endtask

    task automatic test_timeout();
        int base, tr;
        apply_reset();
        ack_b = 4'b0000;
        rst_n = 1'b1;
        base = edge_n;
        tr = 0;
        for (int c = 0; c < 2200; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL timeout_seq edge=%0d obs=%b exp=%b", edge_n - base, obs_vec(), exp_vec());
            end
            if (tr == 0 && to_b) tr = edge_n - base;
        end
`ifdef C3LIB_RSTSEQ_ACK_TIMEOUT_EN
        vectors++;
        if (tr !== 19 + TO || done_b !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_flag got=E%0d done=%b want=E%0d done=1", tr, done_b, 19 + TO);
        end
`else
        vectors++;
        if (tr !== 0 || out_b !== 4'b0001) begin
            miscompares++;
            $display("FAIL ack_wait_forever to=E%0d out=%b want no flag, out=0001", tr, out_b);
        end
        ack_b = 4'b1111;
        repeat (80) @(negedge clk);
        vectors++;
        if (done_b !== 1'b1) begin
            miscompares++;
            $display("FAIL late_ack_done got=%b want=1", done_b);
        end
`endif
    endtask

    task automatic test_scan();
        @(negedge clk);
        rst_n_bypass = 1'b1;
        scan_mode_n = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL scan_seq obs=%b exp=%b", obs_vec(), exp_vec());
            end
            rst_n_bypass = ($urandom_range(0, 15) != 0);
            rst_n = 1'($urandom);
            ack_b = 4'($urandom);
            #1;
            vectors++;
            if (out_a !== {4{rst_n_bypass}} || out_b !== {4{rst_n_bypass}} || done_a !== rst_n_bypass) begin
                miscompares++;
                $display("FAIL scan_comb byp=%b out_a=%b out_b=%b done_a=%b", rst_n_bypass, out_a, out_b, done_a);
            end
        end
        rst_n = 1'b0;
        rst_n_bypass = 1'b0;
        @(negedge clk);
        scan_mode_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d obs=%b exp=%b", c, obs_vec(), exp_vec());
            end
            ack_a = 4'($urandom);
            ack_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            sw_rst_req = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        scan_mode_n = 1'b1;
        rst_n_bypass = 1'b0;
        sw_rst_req = 1'b0;
        ack_a = 4'b0;
        ack_b = 4'b0;
        test_reset();
        test_default_seq();
        test_ack_wait();
        test_sw_req();
        test_async_reset();
        test_timeout();
        test_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
